cpu_run_controller: RTL and testbench

- Synthesizable, parametrised run controller for the RISC-V CPU.
- Drives the CPU reset pulse on a start command, then counts execution cycles.
- Detects program end by a halt instruction or a stalled PC, or ends the run on a cycle timeout.
- Sits between a host/bench and the CPU; monitors the CPU's pc and debug_ins outputs and reports a registered result.

---
 rtl/cpu_run_pkg.sv | 17 +
 rtl/cpu_halt_detector.sv | 58 +++++
 rtl/cpu_run_controller.sv | 129 ++++++++++++
 tb/tb_cpu_run_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller.
//   run_state_t   : controller FSM state encoding (2 bits)
//   HALT_ECALL    : ecall instruction word, the default end-of-program marker
//   HALT_JAL_SELF : "jal x0, 0" self-loop word, an alternative end marker
package cpu_run_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } run_state_t;

  localparam logic [31:0] HALT_ECALL    = 32'h0000_0073;
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000_006F;

endpackage

// File: rtl/cpu_halt_detector.sv
// Program-end detector for the run controller.
//   CLK, RESET : clock and async active-high reset
//   pc         : CPU program counter
//   debug_ins  : instruction currently fetched by the CPU
//   clr        : clears the previous-pc register and stall counter
//   en         : high on every RUN cycle
//   halt_hit   : halt instruction seen, or pc has been stuck long enough
module cpu_halt_detector
  import cpu_run_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          STALL_CYCLES = 8,
  parameter logic [31:0] HALT_INSTR   = HALT_ECALL
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       debug_ins,
  input  logic              clr,
  input  logic              en,
  output logic              halt_hit
);

  localparam int  STALL_W  = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam bit  STALL_EN = (STALL_CYCLES > 0);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_CYCLES);

  logic [ADDR_W-1:0]  prev_pc;
  logic               prev_valid;
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (clr) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      stall_cnt  <= '0;
    end else if (en) begin
      prev_pc    <= pc;
      prev_valid <= 1'b1;
      // Count unchanged-pc cycles; hold at the limit so the counter never wraps.
      if (prev_valid && (pc == prev_pc)) begin
        if (stall_cnt != STALL_LIMIT) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  always_comb begin
    halt_hit = en && ((debug_ins == HALT_INSTR) ||
                      (STALL_EN && (stall_cnt == STALL_LIMIT)));
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the RISC-V CPU: pulses the CPU reset on start, counts
// RUN cycles, and ends the run on a halt instruction, a stalled pc or a
// cycle timeout. All outputs are registered.
//   CLK, RESET  : clock and async active-high reset
//   start       : begin a run (honoured in IDLE or DONE)
//   abort       : in RST_HOLD or RUN, return to IDLE without a result
//   pc          : CPU program counter
//   debug_ins   : instruction currently fetched by the CPU
//   cpu_reset   : active-high reset to the CPU
//   running     : high in RUN
//   done        : high in DONE
//   halted      : run ended by halt instruction or stall
//   timeout     : run ended by cycle timeout
//   cycle_count : RUN cycles elapsed, held in DONE
//   halt_pc     : pc at the halt cycle, 0 on timeout
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int          ADDR_W           = 32,
  parameter int          CNT_W            = 32,
  parameter int          RST_PULSE_CYCLES = 2,
  parameter int          TIMEOUT_CYCLES   = 600,
  parameter int          STALL_CYCLES     = 8,
  parameter logic [31:0] HALT_INSTR       = HALT_ECALL
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       debug_ins,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] halt_pc
);

  localparam int HOLD_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              halt_hit;

  cpu_halt_detector #(
    .ADDR_W       (ADDR_W),
    .STALL_CYCLES (STALL_CYCLES),
    .HALT_INSTR   (HALT_INSTR)
  ) u_halt_det (
    .CLK       (CLK),
    .RESET     (RESET),
    .pc        (pc),
    .debug_ins (debug_ins),
    .clr       (state != RUN),
    .en        (state == RUN),
    .halt_hit  (halt_hit)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      halt_pc     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE keeps the CPU frozen and ignores abort.
          if (start) begin
            state       <= RST_HOLD;
            hold_cnt    <= '0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
          end
        end
        RST_HOLD: begin
          if (abort) begin
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            // cpu_reset falls on the same edge that running rises.
            state       <= RUN;
            cpu_reset   <= 1'b0;
            running     <= 1'b1;
            cycle_count <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
          end else if (halt_hit) begin
            state     <= DONE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
            halted    <= 1'b1;
            halt_pc   <= pc;
          end else if (cycle_count == TO_LAST) begin
            state     <= DONE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            halt_pc   <= '0;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

  localparam int RPC = 3;
  localparam int TO  = 20;
  localparam int ST  = 4;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] JSELF = 32'h0000_006F;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start, abort;
  logic [31:0] pc, debug_ins;
  logic        cpu_reset, running, done, halted, timeout;
  logic [31:0] cycle_count, halt_pc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] tpc  [0:TO-1];
  logic [31:0] tins [0:TO-1];

  cpu_run_controller #(
    .ADDR_W(32), .CNT_W(32), .RST_PULSE_CYCLES(RPC),
    .TIMEOUT_CYCLES(TO), .STALL_CYCLES(ST), .HALT_INSTR(ECALL)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .pc(pc), .debug_ins(debug_ins),
    .cpu_reset(cpu_reset), .running(running), .done(done),
    .halted(halted), .timeout(timeout),
    .cycle_count(cycle_count), .halt_pc(halt_pc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the program trace cycle by cycle and apply the end rules
  // in priority order (halt word, then pc stuck for ST transitions, then timeout).
  task automatic model(output int k_end, output bit is_to, output logic [31:0] hpc);
    k_end = TO - 1; is_to = 1'b1; hpc = '0;
    for (int k = 0; k < TO; k++) begin
      bit stuck;
      stuck = (k >= ST + 1);
      for (int j = 1; j <= ST; j++)
        if (k - j - 1 >= 0 && tpc[k-j] != tpc[k-j-1]) stuck = 1'b0;
      if (tins[k] == ECALL || stuck) begin
        k_end = k; is_to = 1'b0; hpc = tpc[k];
        return;
      end
    end
  endtask

  task automatic fill_random(input int mode);
    logic [31:0] p;
    p = $urandom & 32'hFFFF_FFFC;
    for (int k = 0; k < TO; k++) begin
      int r;
      if (k > 0) begin
        if (mode == 0 || $urandom_range(0, 2) == 0) p = p + 32'd4;
      end
      tpc[k] = p;
      r = $urandom_range(0, 29);
      tins[k] = (r == 0) ? ECALL : (r == 1) ? JSELF : $urandom;
    end
  endtask

  task automatic run_case(input string name, input int abort_at);
    int          k_end;
    bit          is_to, aborted;
    logic [31:0] hpc;
    model(k_end, is_to, hpc);
    aborted = (abort_at >= 0) && (abort_at <= k_end);

    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, " cleared flags"}, {61'd0, done, halted, timeout}, 64'd0);
    check({name, " cleared count"}, cycle_count, 64'd0);
    check({name, " cleared halt_pc"}, halt_pc, 64'd0);
    for (int h = 0; h < RPC; h++) begin
      check({name, " hold cpu_reset/running"}, {62'd0, cpu_reset, running}, 64'd2);
      tick();
    end
    for (int k = 0; k <= k_end; k++) begin
      check({name, " run cpu_reset/running"}, {62'd0, cpu_reset, running}, 64'd1);
      check({name, " run count"}, cycle_count, 64'(k));
      pc        = tpc[k];
      debug_ins = tins[k];
      abort     = (k == abort_at);
      start     = $urandom_range(0, 1);
      tick();
      if (k == abort_at) break;
    end
    start = 1'b0;
    abort = 1'b0;

    if (aborted) begin
      check({name, " abort state"}, {59'd0, cpu_reset, running, done, halted, timeout}, 64'h10);
    end else begin
      check({name, " end state"}, {59'd0, cpu_reset, running, done, halted, timeout},
            {59'd0, 1'b1, 1'b0, 1'b1, !is_to, is_to});
      check({name, " end count"}, cycle_count, 64'(k_end));
      check({name, " end halt_pc"}, halt_pc, {32'd0, hpc});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({name, " abort ignored in done"}, {62'd0, done, halted}, {62'd0, 1'b1, !is_to});
      check({name, " count held"}, cycle_count, 64'(k_end));
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; abort = 1'b0; pc = '0; debug_ins = NOP;
    repeat (3) tick();
    check("reset outputs", {59'd0, cpu_reset, running, done, halted, timeout}, 64'h10);
    check("reset count", cycle_count, 64'd0);
    check("reset halt_pc", halt_pc, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (4) tick();
    check("idle cpu_reset", {62'd0, cpu_reset, running}, 64'd2);

    // Halt instruction at RUN cycle 7, pc = 0x1C.
    for (int k = 0; k < TO; k++) begin tpc[k] = 32'(4 * k); tins[k] = NOP; end
    tins[7] = ECALL;
    run_case("ecall", -1);

    // pc stuck at 0x40 from RUN cycle 2.
    for (int k = 0; k < TO; k++) begin tpc[k] = (k < 2) ? 32'(4 * k) : 32'h40; tins[k] = NOP; end
    tins[1] = JSELF;
    run_case("stall", -1);

    // pc always moving, no halt word: timeout.
    for (int k = 0; k < TO; k++) begin tpc[k] = 32'(4 * k); tins[k] = NOP; end
    run_case("timeout", -1);

    // Halt word on the timeout cycle wins.
    tins[TO-1] = ECALL;
    run_case("ecall at timeout", -1);

    // Abort at RUN cycle 3.
    run_case("abort run", 3);

    // Abort during RST_HOLD.
    start = 1'b1; tick(); start = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (RPC + 1) tick();
    check("abort hold", {61'd0, cpu_reset, running, done}, 64'h4);

    // Randomized runs.
    for (int i = 0; i < 24; i++) begin
      fill_random(i % 2);
      run_case("random", ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO - 1)) : -1);
    end

    // Asynchronous RESET between edges while running.
    for (int k = 0; k < TO; k++) begin tpc[k] = 32'(4 * k); tins[k] = NOP; end
    start = 1'b1; tick(); start = 1'b0;
    repeat (RPC + 3) tick();
    check("pre-reset running", {63'd0, running}, 64'd1);
    #3;
    RESET = 1'b1;
    #1;
    check("async reset outputs", {62'd0, cpu_reset, running}, 64'd2);
    check("async reset count", cycle_count, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    run_case("after reset", -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
